// File: rtl/disp7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// slot phase encoding and the all-segments-off pattern.
package disp7_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    ON    = 2'd1,
    DARK  = 2'd2
  } phase_e;

  localparam int SEG_W_MAX = 32;
  localparam logic [SEG_W_MAX-1:0] SEG_BLANK = '1;

endpackage

// File: rtl/disp7_frame_buf.sv
// Double buffer for display frames: a pending slot filled by the valid/ready
// handshake, copied into the displayed shadow only at a frame boundary.
module disp7_frame_buf
  import disp7_pkg::*;
#(
  parameter int N_DIG = 8,
  parameter int SEG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   boundary,
  input  logic                   valid,
  input  logic [N_DIG*SEG_W-1:0] number,
  input  logic [N_DIG-1:0]       dig_en,
  input  logic [3:0]             bright,
  output logic                   ready,
  output logic [N_DIG*SEG_W-1:0] shadow_data,
  output logic [N_DIG-1:0]       shadow_en,
  output logic [3:0]             shadow_bright
);

  localparam logic [N_DIG*SEG_W-1:0] DATA_BLANK = {N_DIG{SEG_BLANK[SEG_W-1:0]}};

  logic                   pending_full;
  logic [N_DIG*SEG_W-1:0] pending_data;
  logic [N_DIG-1:0]       pending_en;
  logic [3:0]             pending_bright;

  assign ready = ~pending_full;

  // A boundary transfer only happens while pending is full, when ready is low,
  // so transfer and capture can never collide in the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_full   <= 1'b0;
      pending_data   <= DATA_BLANK;
      pending_en     <= '0;
      pending_bright <= 4'd0;
      shadow_data    <= DATA_BLANK;
      shadow_en      <= '0;
      shadow_bright  <= 4'd0;
    end else if (boundary && pending_full) begin
      shadow_data    <= pending_data;
      shadow_en      <= pending_en;
      shadow_bright  <= pending_bright;
      pending_full   <= 1'b0;
    end else if (valid && !pending_full) begin
      pending_data   <= number;
      pending_en     <= dig_en;
      pending_bright <= bright;
      pending_full   <= 1'b1;
    end
  end

endmodule

// File: rtl/disp7_scan.sv
// Time-multiplexed seven-segment driver: one slot of 2^DIV_W clocks per digit,
// with leading anti-ghost blanking and 16-step PWM brightness inside each slot.
module disp7_scan
  import disp7_pkg::*;
#(
  parameter int N_DIG     = 8,
  parameter int SEG_W     = 8,
  parameter int DIV_W     = 14,
  parameter int BLANK_CYC = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   frame_valid_i,
  output logic                   frame_ready_o,
  input  logic [N_DIG*SEG_W-1:0] number_i,
  input  logic [N_DIG-1:0]       dig_en_i,
  input  logic [3:0]             bright_i,
  output logic                   frame_sync_o,
  output logic [SEG_W-1:0]       seg_o,
  output logic [N_DIG-1:0]       an_o
);

  localparam int DIG_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIG - 1);

  logic [DIV_W-1:0]       cnt;
  logic [DIG_W-1:0]       dig;
  logic                   boundary;
  logic [N_DIG*SEG_W-1:0] shadow_data;
  logic [N_DIG-1:0]       shadow_en;
  logic [3:0]             shadow_bright;
  phase_e                 phase;
  logic [SEG_W-1:0]       seg_next;
  logic [N_DIG-1:0]       an_next;

  assign boundary     = (dig == DIG_LAST) && (cnt == '1);
  assign frame_sync_o = boundary;

  disp7_frame_buf #(
    .N_DIG(N_DIG),
    .SEG_W(SEG_W)
  ) u_frame_buf (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .boundary     (boundary),
    .valid        (frame_valid_i),
    .number       (number_i),
    .dig_en       (dig_en_i),
    .bright       (bright_i),
    .ready        (frame_ready_o),
    .shadow_data  (shadow_data),
    .shadow_en    (shadow_en),
    .shadow_bright(shadow_bright)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      dig <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end
    end
  end

  // PWM compares the top four slot-counter bits against brightness.
  always_comb begin
    phase = DARK;
    if (cnt < DIV_W'(BLANK_CYC)) begin
      phase = BLANK;
    end else if ((cnt[DIV_W-1 -: 4] < shadow_bright) && shadow_en[dig]) begin
      phase = ON;
    end
  end

  always_comb begin
    seg_next = SEG_BLANK[SEG_W-1:0];
    an_next  = '1;
    if (phase == ON) begin
      seg_next = shadow_data[dig*SEG_W +: SEG_W];
      an_next  = ~(N_DIG'(1) << dig);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_o <= SEG_BLANK[SEG_W-1:0];
      an_o  <= '1;
    end else begin
      seg_o <= seg_next;
      an_o  <= an_next;
    end
  end

endmodule

// File: tb/tb_disp7_scan.sv
// Bench for disp7_scan with 4 digits and 64-clock slots: cycle-by-cycle
// comparison against a frame-level model plus directed literal spot checks.
module tb_disp7_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [31:0] number = 32'h0;
  logic [3:0]  dig_en = 4'h0;
  logic [3:0]  bright = 4'h0;
  logic        frame_ready;
  logic        frame_sync;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  disp7_scan #(
    .N_DIG(4),
    .SEG_W(8),
    .DIV_W(6),
    .BLANK_CYC(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .frame_valid_i(frame_valid),
    .frame_ready_o(frame_ready),
    .number_i     (number),
    .dig_en_i     (dig_en),
    .bright_i     (bright),
    .frame_sync_o (frame_sync),
    .seg_o        (seg),
    .an_o         (an)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // Frame-level model: position within a 256-clock frame decides the digit
  // and slot offset; frames move pending -> shown only at position 255.
  int          mk = 0;
  logic        m_pend_full = 1'b0;
  logic [31:0] m_pd_data = '1, m_sh_data = '1;
  logic [3:0]  m_pd_en = 4'h0, m_sh_en = 4'h0;
  logic [3:0]  m_pd_br = 4'h0, m_sh_br = 4'h0;
  logic [3:0]  e_an = 4'hF;
  logic [7:0]  e_seg = 8'hFF;
  logic        e_sync = 1'b0;
  logic        e_ready = 1'b1;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mk = 0; m_pend_full = 1'b0;
      m_pd_data = '1; m_sh_data = '1; m_pd_en = 4'h0; m_sh_en = 4'h0;
      m_pd_br = 4'h0; m_sh_br = 4'h0;
      e_an = 4'hF; e_seg = 8'hFF; e_sync = 1'b0; e_ready = 1'b1;
    end else begin
      int pos, d, c;
      pos = mk % 256; d = pos / 64; c = pos % 64;
      e_an = 4'hF; e_seg = 8'hFF;
      if (c >= 4 && (c / 4) < int'(m_sh_br) && m_sh_en[d]) begin
        e_an[d] = 1'b0;
        e_seg = m_sh_data[d*8 +: 8];
      end
      if (pos == 255 && m_pend_full) begin
        m_sh_data = m_pd_data; m_sh_en = m_pd_en; m_sh_br = m_pd_br;
        m_pend_full = 1'b0;
      end else if (frame_valid && !m_pend_full) begin
        m_pd_data = number; m_pd_en = dig_en; m_pd_br = bright;
        m_pend_full = 1'b1;
      end
      mk++;
      e_sync  = (mk % 256 == 255);
      e_ready = !m_pend_full;
    end
  end

  initial forever begin
    @(negedge clk);
    check("an_o", {28'h0, an}, {28'h0, e_an});
    check("seg_o", {24'h0, seg}, {24'h0, e_seg});
    check("frame_sync_o", {31'h0, frame_sync}, {31'h0, e_sync});
    check("frame_ready_o", {31'h0, frame_ready}, {31'h0, e_ready});
  end

  task automatic wait_sync();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_sync) return;
    end
    timeout("wait_sync");
  endtask

  // Output for slot (d,c) of the next frame appears d*64+c+2 samples after sync.
  task automatic slot_check(input string name, input int d, input int c,
                            input logic [3:0] exp_an, input logic [7:0] exp_seg);
    wait_sync();
    repeat (d * 64 + c + 2) @(negedge clk);
    check({name, "_an"}, {28'h0, an}, {28'h0, exp_an});
    check({name, "_seg"}, {24'h0, seg}, {24'h0, exp_seg});
  endtask

  task automatic send(input logic [31:0] num, input logic [3:0] m, input logic [3:0] b);
    @(posedge clk);
    #2;
    frame_valid = 1'b1; number = num; dig_en = m; bright = b;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_ready) begin
        @(posedge clk);
        #2;
        frame_valid = 1'b0;
        $display("frame %08h mask %b bright %0d accepted at %0t", num, m, b, $time);
        return;
      end
    end
    frame_valid = 1'b0;
    timeout("send");
  endtask

  initial begin
    #22 rst_n = 1'b1;
    @(negedge clk);
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_ready", {31'h0, frame_ready}, 32'h1);
    check("rst_sync", {31'h0, frame_sync}, 32'h0);

    wait_sync();
    begin
      int gap = 0;
      for (int i = 1; i <= 600; i++) begin
        @(negedge clk);
        if (frame_sync) begin gap = i; break; end
      end
      check("sync_period", gap, 256);
    end

    send(32'hC0F9A4B0, 4'hF, 4'd15);
    slot_check("d0_c4", 0, 4, 4'hE, 8'hB0);
    slot_check("d0_c3", 0, 3, 4'hF, 8'hFF);
    slot_check("d0_c59", 0, 59, 4'hE, 8'hB0);
    slot_check("d0_c60", 0, 60, 4'hF, 8'hFF);
    slot_check("d2_c30", 2, 30, 4'hB, 8'hF9);

    send(32'h11223344, 4'b0101, 4'd4);
    slot_check("dim_d0_c15", 0, 15, 4'hE, 8'h44);
    slot_check("dim_d0_c16", 0, 16, 4'hF, 8'hFF);
    slot_check("dim_d1_c10", 1, 10, 4'hF, 8'hFF);
    slot_check("dim_d2_c10", 2, 10, 4'hB, 8'h22);

    wait_sync();
    send(32'hAABBCCDD, 4'hF, 4'd15);
    @(negedge clk);
    check("pend_full_ready", {31'h0, frame_ready}, 32'h0);
    send(32'h5EED1234, 4'hF, 4'd15);
    slot_check("held_d3_c20", 3, 20, 4'h7, 8'h5E);

    wait_sync();
    #1;
    frame_valid = 1'b1; number = 32'h01020304; dig_en = 4'hF; bright = 4'd15;
    @(posedge clk);
    #2 frame_valid = 1'b0;
    $display("frame %08h offered on sync clock at %0t", 32'h01020304, $time);
    repeat (12) @(negedge clk);
    check("sync_cap_old_an", {28'h0, an}, 32'hE);
    check("sync_cap_old_seg", {24'h0, seg}, 32'h34);
    slot_check("sync_cap_new", 0, 10, 4'hE, 8'h04);

    send(32'h12345678, 4'hF, 4'd0);
    slot_check("bright0_d0", 0, 30, 4'hF, 8'hFF);
    slot_check("bright0_d3", 3, 40, 4'hF, 8'hFF);

    send(32'h87654321, 4'hF, 4'd15);
    wait_sync();
    repeat (159) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_an", {28'h0, an}, 32'hF);
    check("async_rst_seg", {24'h0, seg}, 32'hFF);
    check("async_rst_ready", {31'h0, frame_ready}, 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    slot_check("post_rst_d0", 0, 10, 4'hF, 8'hFF);
    slot_check("post_rst_d2", 2, 30, 4'hF, 8'hFF);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
